// File: rtl/ercm8_mul_arbiter.sv
// Round-robin sequencer sharing one ERCM8 approximate multiplier among NREQ requesters.
// Each requester has its own mask register; products return tagged with the requester id.
module ercm8_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MASK_W  = 7,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_id,
  input  logic [MASK_W-1:0]    cfg_mask,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  output logic [MASK_W-1:0]    mul_mask,
  input  logic [2*DW-1:0]      mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [2*DW-1:0]      rsp_p,
  output logic                 busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [2:0]          ptr;
  logic [CNT_W-1:0]    cnt;
  logic [MASK_W-1:0]   mask_reg [0:7];
  logic                gnt_vld;
  logic [2:0]          gnt_id;

  // Walk offsets from the highest down so the requester closest to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = 3'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = NREQ'(1) << gnt_id;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand launch, latency count, product capture and mask storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      mul_mask  <= '0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      for (int i = 0; i < 8; i++) mask_reg[i] <= '0;
    end else begin
      if (cfg_we && (int'(cfg_id) < NREQ)) mask_reg[cfg_id] <= cfg_mask;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            mul_a    <= req_a[gnt_id*DW +: DW];
            mul_b    <= req_b[gnt_id*DW +: DW];
            mul_mask <= mask_reg[gnt_id];
            rsp_id   <= gnt_id;
            ptr      <= 3'((int'(gnt_id) + 1) % NREQ);
            cnt      <= '0;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ercm8_mul_arbiter.sv
// Scoreboard bench for ercm8_mul_arbiter: a MUL_LAT=2 instance and a MUL_LAT=1 instance,
// each fed by a behavioural exact multiplier.
module tb_ercm8_mul_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] p;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // MUL_LAT = 2 instance
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        cfg_we;
  logic [2:0]  cfg_id;
  logic [6:0]  cfg_mask;
  logic [7:0]  mul_a, mul_b;
  logic [6:0]  mul_mask;
  logic [15:0] mul_p;
  logic        rsp_valid, rsp_ready, busy;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_p;

  assign mul_p = 16'(mul_a) * 16'(mul_b);

  ercm8_mul_arbiter #(.NREQ(4), .DW(8), .MASK_W(7), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  // MUL_LAT = 1 instance
  logic [3:0]  l1_req_valid, l1_req_ready;
  logic [31:0] l1_req_a, l1_req_b;
  logic [7:0]  l1_mul_a, l1_mul_b;
  logic [6:0]  l1_mul_mask;
  logic [15:0] l1_mul_p;
  logic        l1_rsp_valid, l1_busy;
  logic [2:0]  l1_rsp_id;
  logic [15:0] l1_rsp_p;

  assign l1_mul_p = 16'(l1_mul_a) * 16'(l1_mul_b);

  ercm8_mul_arbiter #(.NREQ(4), .DW(8), .MASK_W(7), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_a(l1_req_a), .req_b(l1_req_b), .cfg_we(1'b0), .cfg_id(3'd0), .cfg_mask(7'd0),
    .mul_a(l1_mul_a), .mul_b(l1_mul_b), .mul_mask(l1_mul_mask), .mul_p(l1_mul_p),
    .rsp_valid(l1_rsp_valid), .rsp_ready(1'b1), .rsp_id(l1_rsp_id), .rsp_p(l1_rsp_p),
    .busy(l1_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready != 4'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [2:0] id, input logic [15:0] p);
    exp_t e;
    e.id = id;
    e.p  = p;
    q.push_back(e);
  endtask

  // Response monitors: a handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_p", 32'(rsp_p), 32'(e.p));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && l1_rsp_valid) begin
      if (q1.size() == 0) chk("l1_rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("l1_rsp_id", 32'(l1_rsp_id), 32'(e.id));
        chk("l1_rsp_p", 32'(l1_rsp_p), 32'(e.p));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int last;
    exp_t e1;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    cfg_we = 1'b0; cfg_id = '0; cfg_mask = '0; rsp_ready = 1'b1;
    l1_req_valid = '0; l1_req_a = '0; l1_req_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_mul_mask", 32'(mul_mask), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_p", 32'(rsp_p), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);

    // Single request from requester 1
    req_valid = 4'b0010; req_a[15:8] = 8'd200; req_b[15:8] = 8'd150;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0010);
    push(3'd1, 16'd30000);
    tick();
    req_valid = '0;
    #1;
    chk("single_busy", 32'(busy), 1);
    chk("single_mul_a", 32'(mul_a), 200);
    chk("single_mul_b", 32'(mul_b), 150);
    chk("single_ready_wait", 32'(req_ready), 0);
    tick();
    chk("single_rv_early", 32'(rsp_valid), 0);
    tick();
    chk("single_rv", 32'(rsp_valid), 1);
    tick();
    chk("single_busy_done", 32'(busy), 0);
    chk("single_rv_done", 32'(rsp_valid), 0);

    // Round robin from pointer 0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd10;
    end
    req_valid = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      wait_grant(ok);
      if (!ok) break;
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      push(3'(k % 4), 16'(((k % 4) + 1) * 10));
      if (k > 0) chk("rr_spacing", 32'(cyc - last), 4);
      last = cyc;
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    chk("rr_busy_done", 32'(busy), 0);

    // Backpressure; pointer is now 1
    rsp_ready = 1'b0;
    req_valid = 4'b0010; req_a[15:8] = 8'd12; req_b[15:8] = 8'd11;
    #1;
    wait_grant(ok);
    push(3'd1, 16'd132);
    tick();
    req_a[15:8] = 8'd7; req_b[15:8] = 8'd3;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_p", 32'(rsp_p), 132);
      chk("bp_mul_a", 32'(mul_a), 12);
      chk("bp_mul_b", 32'(mul_b), 11);
      chk("bp_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    push(3'd1, 16'd21);
    tick();
    chk("bp_regrant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Mask config; pointer is now 2
    cfg_we = 1'b1; cfg_id = 3'd2; cfg_mask = 7'h55;
    tick();
    cfg_we = 1'b0;
    req_valid = 4'b0100; req_a[23:16] = 8'd3; req_b[23:16] = 8'd5;
    #1;
    wait_grant(ok);
    chk("mask_grant", 32'(req_ready), 32'b0100);
    push(3'd2, 16'd15);
    cfg_we = 1'b1; cfg_mask = 7'h0F;
    tick();
    cfg_we = 1'b0; req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("mask_inflight", 32'(mul_mask), 32'h55);
      tick();
    end
    cfg_we = 1'b1; cfg_id = 3'd5; cfg_mask = 7'h7F;
    tick();
    cfg_we = 1'b0;
    req_valid = 4'b0100; req_a[23:16] = 8'd4; req_b[23:16] = 8'd5;
    #1;
    wait_grant(ok);
    push(3'd2, 16'd20);
    tick();
    req_valid = '0;
    chk("mask_new", 32'(mul_mask), 32'h0F);
    repeat (4) tick();
    req_valid = 4'b0010; req_a[15:8] = 8'd2; req_b[15:8] = 8'd9;
    #1;
    wait_grant(ok);
    push(3'd1, 16'd18);
    tick();
    req_valid = '0;
    chk("mask_id5_ignored", 32'(mul_mask), 0);
    repeat (4) tick();

    // Reset mid-WAIT; grant requester 1 so pointer would be 2 without reset
    req_valid = 4'b0010; req_a[15:8] = 8'd9; req_b[15:8] = 8'd9;
    #1;
    wait_grant(ok);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rv", 32'(rsp_valid), 0);
    chk("mrst_mul_a", 32'(mul_a), 0);
    chk("mrst_mul_b", 32'(mul_b), 0);
    chk("mrst_busy", 32'(busy), 0);
    repeat (3) begin
      tick();
      chk("mrst_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 4'b1001; req_a[7:0] = 8'd2; req_b[7:0] = 8'd2;
    req_a[31:24] = 8'd5; req_b[31:24] = 8'd5;
    #1;
    chk("mrst_ptr_grant", 32'(req_ready), 32'b0001);
    push(3'd0, 16'd4);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // MUL_LAT = 1 instance
    l1_req_valid = 4'b0001; l1_req_a[7:0] = 8'd255; l1_req_b[7:0] = 8'd255;
    #1;
    chk("l1_grant", 32'(l1_req_ready), 32'b0001);
    e1.id = 3'd0; e1.p = 16'd65025;
    q1.push_back(e1);
    tick();
    l1_req_valid = '0;
    chk("l1_rv_early", 32'(l1_rsp_valid), 0);
    tick();
    chk("l1_rv", 32'(l1_rsp_valid), 1);
    tick();
    chk("l1_busy_done", 32'(l1_busy), 0);

    repeat (2) tick();
    chk("q_drained", 32'(q.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
